// File: rtl/spatz_pkg.sv
// Shared types for the SIMD result buffer: element widths, writeback entry, pack FSM states.
package spatz_pkg;

    localparam int unsigned WbWidth        = 64;
    localparam int unsigned WbVregIdxWidth = 5;
    localparam int unsigned WbWordIdxWidth = 4;

    typedef enum logic [1:0] {
        EW_8  = 2'd0,
        EW_16 = 2'd1,
        EW_32 = 2'd2,
        EW_64 = 2'd3
    } vew_e;

    typedef enum logic {
        IDLE = 1'b0,
        PACK = 1'b1
    } pack_state_e;

    // Default-width writeback entry; the top builds the same layout from its own parameters.
    typedef struct packed {
        logic [WbWidth-1:0]        data;
        logic [WbVregIdxWidth-1:0] vd;
        logic [WbWordIdxWidth-1:0] word;
        logic [WbWidth/8-1:0]      be;
        logic                      last;
    } wb_entry_t;

    function automatic int unsigned elems_per_word(input int unsigned width, input vew_e sew);
        return width >> (3 + int'(sew));
    endfunction

endpackage

// File: rtl/spatz_wb_fifo.sv
// Depth-entry FIFO of writeback entries with full/empty flags.
module spatz_wb_fifo
    import spatz_pkg::*;
#(
    parameter int unsigned Depth   = 2,
    parameter type         entry_t = wb_entry_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int unsigned AddrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth  = $clog2(Depth + 1);

    entry_t                mem_q [Depth];
    logic [AddrWidth-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]   cnt_q;
    logic                  push_ok, pop_ok;

    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    function automatic logic [AddrWidth-1:0] wrap_inc(input logic [AddrWidth-1:0] p);
        return (p == AddrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wrap_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= wrap_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: storage is not reset; validity is tracked by the counter, so contents are never observed stale.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/spatz_simd_result_buffer.sv
// Writeback buffer behind the SIMD lanes: forwards result words to the VRF and packs
// per-element carry bits of mask-producing ops into dense mask words.
module spatz_simd_result_buffer
    import spatz_pkg::*;
#(
    parameter int unsigned Width        = 64,
    parameter int unsigned Depth        = 2,
    parameter int unsigned VregIdxWidth = 5,
    parameter int unsigned WordIdxWidth = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    res_valid_i,
    output logic                    res_ready_o,
    input  logic [Width-1:0]        res_data_i,
    input  logic [VregIdxWidth-1:0] res_vd_i,
    input  logic [WordIdxWidth-1:0] res_word_i,
    input  logic [Width/8-1:0]      res_be_i,
    input  logic [1:0]              res_sew_i,
    input  logic                    res_mask_op_i,
    input  logic                    res_last_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [Width-1:0]        wb_data_o,
    output logic [VregIdxWidth-1:0] wb_vd_o,
    output logic [WordIdxWidth-1:0] wb_word_o,
    output logic [Width/8-1:0]      wb_be_o,
    output logic                    wb_last_o,
    output logic                    busy_o
);

    localparam int unsigned BeWidth  = Width / 8;
    localparam int unsigned PtrWidth = $clog2(Width);

    typedef struct packed {
        logic [Width-1:0]        data;
        logic [VregIdxWidth-1:0] vd;
        logic [WordIdxWidth-1:0] word;
        logic [BeWidth-1:0]      be;
        logic                    last;
    } entry_t;

    pack_state_e             state_q, state_d;
    logic [Width-1:0]        acc_q, acc_d;
    logic [PtrWidth-1:0]     ptr_q, ptr_d;
    logic [WordIdxWidth-1:0] cnt_q, cnt_d;
    logic [VregIdxWidth-1:0] vd_q, vd_d;
    vew_e                    sew_q, sew_d;

    vew_e                    sew_eff;
    logic [VregIdxWidth-1:0] vd_eff;
    logic [WordIdxWidth-1:0] cnt_eff;
    int                      n_elems;
    logic [Width-1:0]        new_bits, merged;
    logic                    word_full;
    logic                    beat_fire, mask_fire, emit, push, pop;
    logic                    fifo_full, fifo_empty;
    entry_t                  push_entry, head_entry;

    // While packing, the instruction's latched vd/sew govern every beat.
    assign sew_eff   = (state_q == PACK) ? sew_q : vew_e'(res_sew_i);
    assign vd_eff    = (state_q == PACK) ? vd_q  : res_vd_i;
    assign cnt_eff   = (state_q == PACK) ? cnt_q : '0;
    assign n_elems   = int'(elems_per_word(Width, sew_eff));
    assign merged    = acc_q | (new_bits << ptr_q);
    assign word_full = (int'(ptr_q) + n_elems) == int'(Width);

    assign res_ready_o = !fifo_full;
    assign beat_fire   = res_valid_i && res_ready_o;
    assign mask_fire   = beat_fire && res_mask_op_i;
    assign emit        = mask_fire && (word_full || res_last_i);
    assign push        = (beat_fire && !res_mask_op_i) || emit;
    assign pop         = wb_valid_o && wb_ready_i;

    always_comb begin
        // NOTE: default every comb output first so no path leaves it unassigned (no latches).
        new_bits = '0;
        for (int k = 0; k < int'(Width); k++) begin
            if (k < n_elems) new_bits[k] = res_data_i[PtrWidth'(k << (3 + int'(sew_eff)))];
        end
    end

    always_comb begin
        push_entry = '0;
        if (res_mask_op_i) begin
            push_entry.data = merged;
            push_entry.vd   = vd_eff;
            push_entry.word = cnt_eff;
            push_entry.be   = '1;
            push_entry.last = res_last_i;
        end else begin
            push_entry.data = res_data_i;
            push_entry.vd   = res_vd_i;
            push_entry.word = res_word_i;
            push_entry.be   = res_be_i;
            push_entry.last = res_last_i;
        end
    end

    spatz_wb_fifo #(
        .Depth   (Depth),
        .entry_t (entry_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            vd_q    <= '0;
            sew_q   <= EW_8;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            vd_q    <= vd_d;
            sew_q   <= sew_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mask_fire && !res_last_i) state_d = PACK;
            PACK:    if (mask_fire && res_last_i)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        vd_d  = vd_q;
        sew_d = sew_q;
        if (mask_fire) begin
            if (state_q == IDLE) begin
                vd_d  = res_vd_i;
                sew_d = vew_e'(res_sew_i);
            end
            if (res_last_i) begin
                acc_d = '0;
                ptr_d = '0;
                cnt_d = '0;
            end else if (word_full) begin
                acc_d = '0;
                ptr_d = '0;
                cnt_d = cnt_eff + 1'b1;
            end else begin
                acc_d = merged;
                ptr_d = ptr_q + PtrWidth'(n_elems);
                cnt_d = cnt_eff;
            end
        end
    end

    // Outputs are forced to zero while the FIFO is empty since its storage is not reset.
    always_comb begin
        wb_valid_o = !fifo_empty;
        wb_data_o  = fifo_empty ? '0 : head_entry.data;
        wb_vd_o    = fifo_empty ? '0 : head_entry.vd;
        wb_word_o  = fifo_empty ? '0 : head_entry.word;
        wb_be_o    = fifo_empty ? '0 : head_entry.be;
        wb_last_o  = fifo_empty ? 1'b0 : head_entry.last;
        busy_o     = !fifo_empty || (state_q == PACK);
    end

    normal_beat_in_pack: assert property (@(posedge clk_i) disable iff (rst_i)
        !(beat_fire && !res_mask_op_i && state_q == PACK));

endmodule

// File: tb/tb_spatz_simd_result_buffer.sv
// Directed bench for spatz_simd_result_buffer: vector table plus multi-cycle pack/stall/reset sequences.
module tb_spatz_simd_result_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        res_valid_i, res_ready_o;
    logic [63:0] res_data_i;
    logic [4:0]  res_vd_i;
    logic [3:0]  res_word_i;
    logic [7:0]  res_be_i;
    logic [1:0]  res_sew_i;
    logic        res_mask_op_i, res_last_i;
    logic        wb_valid_o, wb_ready_i;
    logic [63:0] wb_data_o;
    logic [4:0]  wb_vd_o;
    logic [3:0]  wb_word_o;
    logic [7:0]  wb_be_o;
    logic        wb_last_o, busy_o;

    always #5 clk = ~clk;

    spatz_simd_result_buffer #(
        .Width        (64),
        .Depth        (2),
        .VregIdxWidth (5),
        .WordIdxWidth (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .res_valid_i   (res_valid_i),
        .res_ready_o   (res_ready_o),
        .res_data_i    (res_data_i),
        .res_vd_i      (res_vd_i),
        .res_word_i    (res_word_i),
        .res_be_i      (res_be_i),
        .res_sew_i     (res_sew_i),
        .res_mask_op_i (res_mask_op_i),
        .res_last_i    (res_last_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_data_o     (wb_data_o),
        .wb_vd_o       (wb_vd_o),
        .wb_word_o     (wb_word_o),
        .wb_be_o       (wb_be_o),
        .wb_last_o     (wb_last_o),
        .busy_o        (busy_o)
    );

    typedef struct {
        logic [63:0] data;
        logic [4:0]  vd;
        logic [3:0]  word;
        logic [7:0]  be;
        logic        last;
    } wr_t;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  vd;
        logic [3:0]  word;
        logic [7:0]  be;
        logic        last;
        wr_t         exp;
    } vec_t;

    int  n_checks = 0;
    int  n_errors = 0;
    wr_t seen [$];

    always @(negedge clk) begin
        if (!rst && wb_valid_o && wb_ready_i)
            seen.push_back('{wb_data_o, wb_vd_o, wb_word_o, wb_be_o, wb_last_o});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input string name, input int idx, input wr_t e);
        if (idx < seen.size()) begin
            check({name, "_data"}, seen[idx].data, e.data);
            check({name, "_vd"},   64'(seen[idx].vd),   64'(e.vd));
            check({name, "_word"}, 64'(seen[idx].word), 64'(e.word));
            check({name, "_be"},   64'(seen[idx].be),   64'(e.be));
            check({name, "_last"}, 64'(seen[idx].last), 64'(e.last));
        end else begin
            check({name, "_missing"}, 64'(seen.size()), 64'(idx + 1));
        end
    endtask

    task automatic drive_beat(input logic [63:0] data, input logic [4:0] vd, input logic [3:0] word,
                              input logic [7:0] be, input logic [1:0] sew, input logic mask,
                              input logic last);
        res_data_i    = data;
        res_vd_i      = vd;
        res_word_i    = word;
        res_be_i      = be;
        res_sew_i     = sew;
        res_mask_op_i = mask;
        res_last_i    = last;
        res_valid_i   = 1'b1;
    endtask

    // Holds the beat until accepted (bounded), returns #1 after the accepting edge.
    task automatic finish_beat();
        int t = 0;
        while (!res_ready_o && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check("accept_timeout", 64'(res_ready_o), 64'd1);
        @(posedge clk); #1;
        res_valid_i = 1'b0;
    endtask

    task automatic push_beat(input logic [63:0] data, input logic [4:0] vd, input logic [3:0] word,
                             input logic [7:0] be, input logic [1:0] sew, input logic mask,
                             input logic last);
        drive_beat(data, vd, word, be, sew, mask, last);
        finish_beat();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wb_valid"},  64'(wb_valid_o),  64'd0);
        check({tag, "_wb_data"},   wb_data_o,        64'd0);
        check({tag, "_wb_be"},     64'(wb_be_o),     64'd0);
        check({tag, "_wb_last"},   64'(wb_last_o),   64'd0);
        check({tag, "_busy"},      64'(busy_o),      64'd0);
        check({tag, "_res_ready"}, 64'(res_ready_o), 64'd1);
    endtask

    vec_t vecs [4];

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{64'h1111_1111_1111_1111, 5'd1,  4'd0,  8'hFF, 1'b0,
                    '{64'h1111_1111_1111_1111, 5'd1,  4'd0,  8'hFF, 1'b0}};
        vecs[1] = '{64'h2222_2222_2222_2222, 5'd1,  4'd1,  8'hFF, 1'b0,
                    '{64'h2222_2222_2222_2222, 5'd1,  4'd1,  8'hFF, 1'b0}};
        vecs[2] = '{64'h3333_3333_3333_3333, 5'd1,  4'd2,  8'hFF, 1'b1,
                    '{64'h3333_3333_3333_3333, 5'd1,  4'd2,  8'hFF, 1'b1}};
        vecs[3] = '{64'h0123_4567_89AB_CDEF, 5'd30, 4'd15, 8'h0F, 1'b1,
                    '{64'h0123_4567_89AB_CDEF, 5'd30, 4'd15, 8'h0F, 1'b1}};

        rst = 1'b1;
        res_valid_i = 1'b0; res_data_i = '0; res_vd_i = '0; res_word_i = '0;
        res_be_i = '0; res_sew_i = '0; res_mask_op_i = 1'b0; res_last_i = 1'b0;
        wb_ready_i = 1'b0;
        #1 check_idle_outputs("in_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");

        // Normal path, one-cycle latency, order preserved.
        wb_ready_i = 1'b1;
        seen.delete();
        for (int i = 0; i < 4; i++) begin
            push_beat(vecs[i].data, vecs[i].vd, vecs[i].word, vecs[i].be, 2'd0, 1'b0, vecs[i].last);
            check($sformatf("lat%0d_valid", i), 64'(wb_valid_o), 64'd1);
            check($sformatf("lat%0d_data", i),  wb_data_o, vecs[i].exp.data);
            check($sformatf("lat%0d_word", i),  64'(wb_word_o), 64'(vecs[i].exp.word));
        end
        repeat (3) @(posedge clk); #1;
        check("normal_count", 64'(seen.size()), 64'd4);
        for (int i = 0; i < 4; i++) expect_write($sformatf("normal%0d", i), i, vecs[i].exp);

        // Backpressure: two accepted, third stalls, fields stable.
        wb_ready_i = 1'b0;
        seen.delete();
        push_beat(64'hA0A0_A0A0_A0A0_A0A0, 5'd4, 4'd0, 8'hFF, 2'd0, 1'b0, 1'b0);
        push_beat(64'hB1B1_B1B1_B1B1_B1B1, 5'd4, 4'd1, 8'hF0, 2'd0, 1'b0, 1'b0);
        check("bp_full_ready", 64'(res_ready_o), 64'd0);
        drive_beat(64'hC2C2_C2C2_C2C2_C2C2, 5'd4, 4'd2, 8'h3C, 2'd0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_stall%0d_ready", c), 64'(res_ready_o), 64'd0);
            check($sformatf("bp_stall%0d_data", c), wb_data_o, 64'hA0A0_A0A0_A0A0_A0A0);
            check($sformatf("bp_stall%0d_be", c), 64'(wb_be_o), 64'hFF);
        end
        wb_ready_i = 1'b1;
        finish_beat();
        repeat (4) @(posedge clk); #1;
        check("bp_count", 64'(seen.size()), 64'd3);
        expect_write("bp0", 0, '{64'hA0A0_A0A0_A0A0_A0A0, 5'd4, 4'd0, 8'hFF, 1'b0});
        expect_write("bp1", 1, '{64'hB1B1_B1B1_B1B1_B1B1, 5'd4, 4'd1, 8'hF0, 1'b0});
        expect_write("bp2", 2, '{64'hC2C2_C2C2_C2C2_C2C2, 5'd4, 4'd2, 8'h3C, 1'b1});

        // Mask pack SEW=8: element LSBs carry 1,0,1,0... per byte pattern 0b10101010.
        seen.delete();
        for (int b = 0; b < 8; b++) begin
            push_beat(64'hFFFE_FFFE_FFFE_FFFE, (b == 0) ? 5'd9 : 5'd3, 4'd5, 8'h00,
                      (b == 0) ? 2'd0 : 2'd3, 1'b1, b == 7);
            if (b == 0) begin
                check("sew8_busy_first", 64'(busy_o), 64'd1);
                check("sew8_no_early_write", 64'(wb_valid_o), 64'd0);
            end
        end
        repeat (3) @(posedge clk); #1;
        check("sew8_count", 64'(seen.size()), 64'd1);
        expect_write("sew8", 0, '{64'hAAAA_AAAA_AAAA_AAAA, 5'd9, 4'd0, 8'hFF, 1'b1});
        check("sew8_idle_busy", 64'(busy_o), 64'd0);

        // Partial pack SEW=64: carries 1,0,1 -> 0x5.
        seen.delete();
        push_beat(64'hDEAD_BEEF_0000_0001, 5'd12, 4'd7, 8'h00, 2'd3, 1'b1, 1'b0);
        push_beat(64'hFFFF_FFFF_FFFF_FFFE, 5'd1,  4'd7, 8'h00, 2'd0, 1'b1, 1'b0);
        push_beat(64'h8000_0000_0000_0001, 5'd1,  4'd7, 8'h00, 2'd1, 1'b1, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("part_count", 64'(seen.size()), 64'd1);
        expect_write("part", 0, '{64'h5, 5'd12, 4'd0, 8'hFF, 1'b1});
        check("part_idle_busy", 64'(busy_o), 64'd0);

        // Multi-word pack SEW=64: 128 carries of 1 -> two full words.
        seen.delete();
        for (int b = 0; b < 128; b++)
            push_beat((b % 2 == 0) ? 64'h1 : 64'hFFFF_FFFF_FFFF_FFFF, (b == 0) ? 5'd20 : 5'd0,
                      4'd0, 8'h00, 2'd3, 1'b1, b == 127);
        repeat (3) @(posedge clk); #1;
        check("multi_count", 64'(seen.size()), 64'd2);
        expect_write("multi0", 0, '{64'hFFFF_FFFF_FFFF_FFFF, 5'd20, 4'd0, 8'hFF, 1'b0});
        expect_write("multi1", 1, '{64'hFFFF_FFFF_FFFF_FFFF, 5'd20, 4'd1, 8'hFF, 1'b1});

        // Reset mid-stream after 3 pushes with 2 entries held.
        wb_ready_i = 1'b0;
        push_beat(64'h0101, 5'd2, 4'd0, 8'hFF, 2'd0, 1'b0, 1'b0);
        push_beat(64'h0202, 5'd2, 4'd1, 8'hFF, 2'd0, 1'b0, 1'b0);
        wb_ready_i = 1'b1;
        @(posedge clk); #1;
        wb_ready_i = 1'b0;
        push_beat(64'h0303, 5'd2, 4'd2, 8'hFF, 2'd0, 1'b0, 1'b1);
        check("rst_pre_full", 64'(res_ready_o), 64'd0);
        rst = 1'b1;
        #1 check_idle_outputs("rst_mid");
        seen.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        wb_ready_i = 1'b1;
        repeat (5) @(posedge clk); #1;
        check("rst_nothing_emitted", 64'(seen.size()), 64'd0);

        // Reset during a pack discards the partial accumulator.
        push_beat(64'h1, 5'd6, 4'd0, 8'h00, 2'd3, 1'b1, 1'b0);
        push_beat(64'h1, 5'd6, 4'd0, 8'h00, 2'd3, 1'b1, 1'b0);
        rst = 1'b1;
        #1 check("rst_pack_busy", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen.delete();
        push_beat(64'h1, 5'd8, 4'd0, 8'h00, 2'd3, 1'b1, 1'b1);
        repeat (3) @(posedge clk); #1;
        check("rst_pack_count", 64'(seen.size()), 64'd1);
        expect_write("rst_pack", 0, '{64'h1, 5'd8, 4'd0, 8'hFF, 1'b1});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spatz_simd_result_buffer.md
Name: spatz_simd_result_buffer

Overview:
- Writeback stage directly downstream of the SIMD lane array. Accepts one lane result word per beat with its destination tag, buffers it, and presents VRF write requests with byte enables.
- For mask-producing ops (VMADC, VMSBC), it packs the per-element carry bits (bit 0 of each SEW element) across beats into dense mask-register words before writeback.
- Decouples lane issue from VRF write-port arbitration.

Parameters:
- Width, 64, lane/VRF word width in bits; power of two, minimum 64.
- Depth, 2, output FIFO entries; minimum 1.
- VregIdxWidth, 5, vector register index width.
- WordIdxWidth, 4, word-within-vreg index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- res_valid_i  in  1  lane result valid
- res_ready_o  out  1  buffer can accept a beat
- res_data_i  in  Width  lane result word
- res_vd_i  in  VregIdxWidth  destination vreg
- res_word_i  in  WordIdxWidth  destination word index (normal mode)
- res_be_i  in  Width/8  byte enables (normal mode)
- res_sew_i  in  2  rvv_pkg::vew_e element width
- res_mask_op_i  in  1  beat carries per-element carry bits to be packed
- res_last_i  in  1  final beat of the instruction
- wb_valid_o  out  1  VRF write request valid
- wb_ready_i  in  1  VRF write accepted
- wb_data_o  out  Width  write data
- wb_vd_o  out  VregIdxWidth  write vreg
- wb_word_o  out  WordIdxWidth  write word index
- wb_be_o  out  Width/8  write byte enables
- wb_last_o  out  1  last write of the instruction
- busy_o  out  1  FIFO non-empty or pack in progress

Behaviour:
- Reset:
  - Single clock clk_i; reset rst_i is asynchronous and active-high.
  - On reset: FIFO empty, accumulator zero, bit pointer zero, pack word counter zero, state IDLE.
  - Output values during and after reset: wb_valid_o=0, wb_data_o=0, wb_be_o=0, wb_last_o=0, busy_o=0, res_ready_o=1.
  - Reset asserted mid-operation discards all buffered and partially packed data; there is no writeback of partial state.
- Handshakes:
  - A beat transfers when res_valid_i && res_ready_o.
  - A write transfers when wb_valid_o && wb_ready_i.
  - res_ready_o = FIFO not full. It is registered-state-derived only, with no combinational path from wb_ready_i.
  - When the FIFO is full, input stalls even if a pop occurs in the same cycle.
  - wb_* fields hold stable while wb_valid_o=1 and wb_ready_i=0.
- Normal beat (res_mask_op_i=0, state IDLE):
  - Pushes {res_data_i, res_vd_i, res_word_i, res_be_i, res_last_i} into the FIFO.
  - Earliest appearance on wb_* is the next cycle, so latency is 1.
  - Order is preserved.
- Mask packing:
  - Per beat, the block extracts N = Width/SEW bits: bit k is res_data_i[k*SEW]. For Width=64 and SEW 8/16/32/64, N = 8/4/2/1.
  - The N bits are written into the accumulator at [ptr +: N], and ptr advances by N.
  - First mask beat in IDLE: latch vd and sew, set the word counter to 0, and go to PACK. A first beat that also has res_last_i set emits immediately and stays IDLE.
  - In PACK, res_vd_i, res_sew_i and res_word_i are ignored; the latched values are used.
  - Emit: when ptr+N == Width, or when res_last_i is set, push {accumulator with new bits merged, latched vd, counter, be all ones, last=res_last_i}.
    - Unwritten high bits are zero (tail-agnostic).
    - After an emit: accumulator cleared, ptr=0, counter+1.
  - On res_last_i: state returns to IDLE, counter=0.
  - A mask beat needing no emit is still accepted only when res_ready_o=1, for uniform handshake.
  - A normal beat arriving in PACK is a protocol violation; the upstream stage guarantees it never happens. Simulation assertion flags it.
- Simultaneous push and pop with the FIFO non-full: both occur; occupancy is unchanged.
- Empty FIFO: wb_valid_o=0.
- busy_o = FIFO non-empty || state==PACK.

Decomposition:
- spatz_pkg gets:
  - typedef wb_entry_t {data, vd, word, be, last};
  - typedef pack_state_e {IDLE, PACK};
  - function elems_per_word(sew) returning Width/SEW.
- Sub-module: spatz_wb_fifo, a generic Depth-entry FIFO of wb_entry_t with full/empty flags and an asynchronous active-high reset.
- Packing logic and the state machine stay in the top module.

Test Plan:
- Reset with rst_i=1 mid-stream after 3 pushes, FIFO holding 2 entries -> wb_valid_o=0 immediately, busy_o=0, res_ready_o=1. Nothing emitted after release.
- Normal path: 3 beats with data 0x11..,0x22..,0x33.., word 0,1,2, be 0xFF, wb_ready_i=1 -> same data and words in order, each 1 cycle after acceptance.
- Backpressure: Depth=2, wb_ready_i=0, 3 beats offered -> 2 accepted, then res_ready_o=0. Raise wb_ready_i -> all 3 written in order, wb_* stable while stalled.
- Mask pack SEW=8: 8 beats, each with carries 0b10101010 in element LSBs -> exactly one write, wb_data_o=0xAAAA_AAAA_AAAA_AAAA, wb_word_o=0, wb_vd_o=latched vd.
- Partial pack SEW=64: 3 beats, carries 1,0,1, last on 3rd -> one write, wb_data_o=0x5, wb_last_o=1, be=0xFF. State returns to IDLE.
- Multi-word pack SEW=64: 128 beats, all carries 1 -> two writes with word 0 and word 1, data all ones, wb_last_o only on the second.
